// File: rtl/fetch_pkt_reader.sv
// rtl/fetch_pkt_reader.sv - fetch packet reader feeding two in-order decode lanes (optional FETCH_READER_BYPASS_EN)
module fetch_pkt_reader #(
    parameter logic [31:0] PC_RESET_VAL = 32'h1c00_0000,
    parameter logic [31:0] INST_NOP_VAL = 32'h0340_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fifo_valid_i,
    output logic        fifo_ready_o,
    input  logic [31:0] fifo_inst0_i,
    input  logic [31:0] fifo_inst1_i,
    input  logic [31:0] fifo_pc_i,
    input  logic [31:0] fifo_pc_next_i,
    input  logic        fifo_pc_taken_i,
    input  logic [31:0] fifo_badv_i,
    input  logic [6:0]  fifo_exception_i,
    input  logic [1:0]  fifo_excp_flag_i,
    output logic        id_valid0_o,
    output logic        id_valid1_o,
    input  logic        id_ready0_i,
    input  logic        id_ready1_i,
    output logic [31:0] id_inst0_o,
    output logic [31:0] id_inst1_o,
    output logic [31:0] id_pc0_o,
    output logic [31:0] id_pc1_o,
    output logic        id_pred_taken0_o,
    output logic        id_pred_taken1_o,
    output logic [31:0] id_pred_target_o,
    output logic [1:0]  id_excp_flag0_o,
    output logic [6:0]  id_exception0_o,
    output logic [31:0] id_badv0_o
);

    localparam logic [31:0] TARGET_RST = PC_RESET_VAL + 32'd8;

    // Two-slot packet register; slot B always follows slot A in program order.
    logic        vld_a_q, vld_a_d;
    logic        vld_b_q, vld_b_d;
    logic [31:0] inst_a_q, inst_a_d;
    logic [31:0] inst_b_q, inst_b_d;
    logic [31:0] pc_a_q, pc_a_d;
    logic [31:0] pc_b_q, pc_b_d;
    logic        pred_a_q, pred_a_d;
    logic        pred_b_q, pred_b_d;
    logic [31:0] target_q, target_d;
    logic [1:0]  excp_flag_q, excp_flag_d;
    logic [6:0]  exception_q, exception_d;
    logic [31:0] badv_q, badv_d;

    // Incoming packet split into per-slot view.
    logic [31:0] pc_plus4;
    logic        s_vld_b;
    logic        s_pred_a;
    logic        s_pred_b;

    // Lane view before flush masking and idle substitution.
    logic        lane0_vld, lane1_vld;
    logic [31:0] lane0_inst, lane1_inst;
    logic [31:0] lane0_pc, lane1_pc;
    logic        lane0_pred, lane1_pred;
    logic [31:0] lane_target;
    logic [1:0]  lane_excp_flag;
    logic [6:0]  lane_exception;
    logic [31:0] lane_badv;

    logic        acc0, acc1;
    logic        buf_empty;
    logic        drain;

`ifdef FETCH_READER_BYPASS_EN
    logic        byp;
    assign byp = !vld_a_q && fifo_valid_i && !flush_i && !rst_i;
`endif

    // Second instruction is only usable when the packet is sequential and fault-free;
    // the prediction belongs to whichever instruction ends the packet.
    assign pc_plus4  = fifo_pc_i + 32'd4;
    assign s_vld_b   = (fifo_excp_flag_i == 2'b00) && (fifo_pc_next_i != pc_plus4);
    assign s_pred_a  = fifo_pc_taken_i && !s_vld_b;
    assign s_pred_b  = fifo_pc_taken_i && s_vld_b;

    // Select what each lane shows: held slots, or the live packet when bypassing an empty buffer.
    always_comb begin
        lane0_vld      = vld_a_q;
        lane1_vld      = vld_b_q;
        lane0_inst     = inst_a_q;
        lane1_inst     = inst_b_q;
        lane0_pc       = pc_a_q;
        lane1_pc       = pc_b_q;
        lane0_pred     = pred_a_q;
        lane1_pred     = pred_b_q;
        lane_target    = target_q;
        lane_excp_flag = excp_flag_q;
        lane_exception = exception_q;
        lane_badv      = badv_q;
`ifdef FETCH_READER_BYPASS_EN
        if (byp) begin
            lane0_vld      = 1'b1;
            lane1_vld      = s_vld_b;
            lane0_inst     = fifo_inst0_i;
            lane1_inst     = fifo_inst1_i;
            lane0_pc       = fifo_pc_i;
            lane1_pc       = pc_plus4;
            lane0_pred     = s_pred_a;
            lane1_pred     = s_pred_b;
            lane_target    = fifo_pc_next_i;
            lane_excp_flag = fifo_excp_flag_i;
            lane_exception = fifo_exception_i;
            lane_badv      = fifo_badv_i;
        end
`endif
    end

    // Decode-facing outputs; idle lanes show NOP at the reset PC with no status.
    always_comb begin
        id_valid0_o      = lane0_vld && !flush_i;
        id_valid1_o      = lane1_vld && lane0_vld && !flush_i;
        id_inst0_o       = lane0_vld ? lane0_inst : INST_NOP_VAL;
        id_pc0_o         = lane0_vld ? lane0_pc : PC_RESET_VAL;
        id_pred_taken0_o = lane0_vld && lane0_pred;
        id_inst1_o       = lane1_vld ? lane1_inst : INST_NOP_VAL;
        id_pc1_o         = lane1_vld ? lane1_pc : PC_RESET_VAL;
        id_pred_taken1_o = lane1_vld && lane1_pred;
        id_pred_target_o = lane0_vld ? lane_target : TARGET_RST;
        id_excp_flag0_o  = lane0_vld ? lane_excp_flag : 2'b00;
        id_exception0_o  = lane0_vld ? lane_exception : 7'd0;
        id_badv0_o       = lane0_vld ? lane_badv : PC_RESET_VAL;
    end

    // Accept accounting; lane 1 counts only on top of lane 0.
    always_comb begin
        acc0         = id_valid0_o && id_ready0_i;
        acc1         = acc0 && id_valid1_o && id_ready1_i;
        buf_empty    = !vld_a_q;
        drain        = acc1 || (acc0 && !vld_b_q);
        fifo_ready_o = fifo_valid_i && !flush_i && !rst_i && (buf_empty || drain);
    end

    // Slot next-state: flush, load on pop, full drain, or shift leftover into slot A.
    always_comb begin
        vld_a_d     = vld_a_q;
        vld_b_d     = vld_b_q;
        inst_a_d    = inst_a_q;
        inst_b_d    = inst_b_q;
        pc_a_d      = pc_a_q;
        pc_b_d      = pc_b_q;
        pred_a_d    = pred_a_q;
        pred_b_d    = pred_b_q;
        target_d    = target_q;
        excp_flag_d = excp_flag_q;
        exception_d = exception_q;
        badv_d      = badv_q;
        if (flush_i) begin
            vld_a_d = 1'b0;
            vld_b_d = 1'b0;
        end else if (fifo_ready_o) begin
            vld_a_d     = 1'b1;
            vld_b_d     = s_vld_b;
            inst_a_d    = fifo_inst0_i;
            inst_b_d    = fifo_inst1_i;
            pc_a_d      = fifo_pc_i;
            pc_b_d      = pc_plus4;
            pred_a_d    = s_pred_a;
            pred_b_d    = s_pred_b;
            target_d    = fifo_pc_next_i;
            excp_flag_d = fifo_excp_flag_i;
            exception_d = fifo_exception_i;
            badv_d      = fifo_badv_i;
`ifdef FETCH_READER_BYPASS_EN
            // Lanes already taken straight from the FIFO are not stored.
            if (byp) begin
                if (acc1 || (acc0 && !s_vld_b)) begin
                    vld_a_d = 1'b0;
                    vld_b_d = 1'b0;
                end else if (acc0) begin
                    vld_b_d  = 1'b0;
                    inst_a_d = fifo_inst1_i;
                    pc_a_d   = pc_plus4;
                    pred_a_d = s_pred_b;
                end
            end
`endif
        end else if (drain) begin
            vld_a_d = 1'b0;
            vld_b_d = 1'b0;
        end else if (acc0) begin
            vld_b_d  = 1'b0;
            inst_a_d = inst_b_q;
            pc_a_d   = pc_b_q;
            pred_a_d = pred_b_q;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_a_q     <= 1'b0;
            vld_b_q     <= 1'b0;
            inst_a_q    <= INST_NOP_VAL;
            inst_b_q    <= INST_NOP_VAL;
            pc_a_q      <= PC_RESET_VAL;
            pc_b_q      <= PC_RESET_VAL;
            pred_a_q    <= 1'b0;
            pred_b_q    <= 1'b0;
            target_q    <= TARGET_RST;
            excp_flag_q <= 2'b00;
            exception_q <= 7'd0;
            badv_q      <= PC_RESET_VAL;
        end else begin
            vld_a_q     <= vld_a_d;
            vld_b_q     <= vld_b_d;
            inst_a_q    <= inst_a_d;
            inst_b_q    <= inst_b_d;
            pc_a_q      <= pc_a_d;
            pc_b_q      <= pc_b_d;
            pred_a_q    <= pred_a_d;
            pred_b_q    <= pred_b_d;
            target_q    <= target_d;
            excp_flag_q <= excp_flag_d;
            exception_q <= exception_d;
            badv_q      <= badv_d;
        end
    end

endmodule

// File: tb/tb_fetch_pkt_reader.sv
// tb/tb_fetch_pkt_reader.sv - directed self-checking bench for fetch_pkt_reader
module tb_fetch_pkt_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pc_next, fifo_badv;
    logic        fifo_pc_taken;
    logic [6:0]  fifo_exception;
    logic [1:0]  fifo_excp_flag;
    logic        id_valid0, id_valid1, id_ready0, id_ready1;
    logic [31:0] id_inst0, id_inst1, id_pc0, id_pc1, id_pred_target, id_badv0;
    logic        id_pred_taken0, id_pred_taken1;
    logic [1:0]  id_excp_flag0;
    logic [6:0]  id_exception0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pkt_reader dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .fifo_valid_i     (fifo_valid),
        .fifo_ready_o     (fifo_ready),
        .fifo_inst0_i     (fifo_inst0),
        .fifo_inst1_i     (fifo_inst1),
        .fifo_pc_i        (fifo_pc),
        .fifo_pc_next_i   (fifo_pc_next),
        .fifo_pc_taken_i  (fifo_pc_taken),
        .fifo_badv_i      (fifo_badv),
        .fifo_exception_i (fifo_exception),
        .fifo_excp_flag_i (fifo_excp_flag),
        .id_valid0_o      (id_valid0),
        .id_valid1_o      (id_valid1),
        .id_ready0_i      (id_ready0),
        .id_ready1_i      (id_ready1),
        .id_inst0_o       (id_inst0),
        .id_inst1_o       (id_inst1),
        .id_pc0_o         (id_pc0),
        .id_pc1_o         (id_pc1),
        .id_pred_taken0_o (id_pred_taken0),
        .id_pred_taken1_o (id_pred_taken1),
        .id_pred_target_o (id_pred_target),
        .id_excp_flag0_o  (id_excp_flag0),
        .id_exception0_o  (id_exception0),
        .id_badv0_o       (id_badv0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [31:0] pc, input logic [31:0] pc_next, input logic taken,
                           input logic [31:0] i0, input logic [31:0] i1);
        fifo_pc        = pc;
        fifo_pc_next   = pc_next;
        fifo_pc_taken  = taken;
        fifo_inst0     = i0;
        fifo_inst1     = i1;
        fifo_excp_flag = 2'b00;
        fifo_exception = 7'd0;
        fifo_badv      = 32'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fifo_valid = 1'b1;
        id_ready0 = 1'b1; id_ready1 = 1'b1;
        set_pkt(32'h1c00_0000, 32'h1c00_0008, 1'b0, 32'h1111_0000, 32'h1111_0001);
        #1;
        chk("rst_fifo_ready_async", 32'(fifo_ready), 32'd0);

        tick();
        chk("rst_valid0", 32'(id_valid0), 32'd0);
        chk("rst_valid1", 32'(id_valid1), 32'd0);
        chk("rst_pc0", id_pc0, 32'h1c00_0000);
        chk("rst_inst0", id_inst0, 32'h0340_0000);
        chk("rst_target", id_pred_target, 32'h1c00_0008);
        chk("rst_badv0", id_badv0, 32'h1c00_0000);
        chk("rst_fifo_ready", 32'(fifo_ready), 32'd0);
        tick();
        chk("rst2_fifo_ready", 32'(fifo_ready), 32'd0);
        chk("rst2_valid0", 32'(id_valid0), 32'd0);

        rst = 1'b0;
        #1;
        chk("empty_fifo_ready", 32'(fifo_ready), 32'd1);
        chk("empty_valid0", 32'(id_valid0), 32'd0);

        tick();
        chk("full_valid0", 32'(id_valid0), 32'd1);
        chk("full_valid1", 32'(id_valid1), 32'd1);
        chk("full_pc0", id_pc0, 32'h1c00_0000);
        chk("full_pc1", id_pc1, 32'h1c00_0004);
        chk("full_inst0", id_inst0, 32'h1111_0000);
        chk("full_inst1", id_inst1, 32'h1111_0001);
        chk("full_fifo_ready", 32'(fifo_ready), 32'd1);

        set_pkt(32'h1c00_0008, 32'h1c00_0010, 1'b0, 32'h2222_0000, 32'h2222_0001);
        tick();
        chk("b2b_pc0", id_pc0, 32'h1c00_0008);
        chk("b2b_valid1", 32'(id_valid1), 32'd1);
        chk("b2b_inst1", id_inst1, 32'h2222_0001);

        id_ready1 = 1'b0;
        set_pkt(32'h1c00_0010, 32'h1c00_0014, 1'b1, 32'h3333_0000, 32'h3333_0001);
        #1;
        chk("partial_fifo_ready", 32'(fifo_ready), 32'd0);
        tick();
        chk("partial_valid0", 32'(id_valid0), 32'd1);
        chk("partial_valid1", 32'(id_valid1), 32'd0);
        chk("partial_pc0", id_pc0, 32'h1c00_000c);
        chk("partial_inst0", id_inst0, 32'h2222_0001);
        chk("partial_pc1_idle", id_pc1, 32'h1c00_0000);
        chk("partial_drain_ready", 32'(fifo_ready), 32'd1);

        tick();
        chk("taken_valid0", 32'(id_valid0), 32'd1);
        chk("taken_valid1", 32'(id_valid1), 32'd0);
        chk("taken_pc0", id_pc0, 32'h1c00_0010);
        chk("taken_pred0", 32'(id_pred_taken0), 32'd1);
        chk("taken_pred1", 32'(id_pred_taken1), 32'd0);
        chk("taken_target", id_pred_target, 32'h1c00_0014);

        set_pkt(32'h1c00_0020, 32'h1c00_0028, 1'b0, 32'h4444_0000, 32'h4444_0001);
        fifo_excp_flag = 2'b01;
        fifo_exception = 7'h08;
        fifo_badv      = 32'h1c00_0020;
        tick();
        chk("excp_valid0", 32'(id_valid0), 32'd1);
        chk("excp_valid1", 32'(id_valid1), 32'd0);
        chk("excp_flag0", 32'(id_excp_flag0), 32'd1);
        chk("excp_code0", 32'(id_exception0), 32'h08);
        chk("excp_badv0", id_badv0, 32'h1c00_0020);
        chk("excp_pc0", id_pc0, 32'h1c00_0020);

        set_pkt(32'h1c00_0030, 32'h1c00_0038, 1'b0, 32'h5555_0000, 32'h5555_0001);
        tick();
        id_ready0 = 1'b0;
        id_ready1 = 1'b1;
        #1;
        chk("hold_pc0", id_pc0, 32'h1c00_0030);
        chk("hold_excp_cleared", 32'(id_excp_flag0), 32'd0);
        chk("r1_only_fifo_ready", 32'(fifo_ready), 32'd0);
        tick();
        chk("r1_only_pc0", id_pc0, 32'h1c00_0030);
        chk("r1_only_valid1", 32'(id_valid1), 32'd1);

        set_pkt(32'h1c00_0040, 32'h1c00_0048, 1'b0, 32'h6666_0000, 32'h6666_0001);
        id_ready1 = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_fifo_ready", 32'(fifo_ready), 32'd0);
        chk("flush_valid0_same", 32'(id_valid0), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("postflush_valid0", 32'(id_valid0), 32'd0);
        chk("postflush_valid1", 32'(id_valid1), 32'd0);
        chk("postflush_inst0", id_inst0, 32'h0340_0000);
        chk("postflush_fifo_ready", 32'(fifo_ready), 32'd1);
        id_ready0 = 1'b1;
        id_ready1 = 1'b1;
        tick();
        chk("reload_pc0", id_pc0, 32'h1c00_0040);
        chk("reload_valid1", 32'(id_valid1), 32'd1);

        fifo_valid = 1'b0;
        #1;
        chk("novalid_fifo_ready", 32'(fifo_ready), 32'd0);
        tick();
        chk("drained_valid0", 32'(id_valid0), 32'd0);
        chk("drained_pc0", id_pc0, 32'h1c00_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
